// File: rtl/fetch_redirect_ctrl.sv
// Front-end redirect arbiter: picks ROB flush / execute mispredict / decode jump,
// holds the winner on branch/branch_loc until fetch takes it, then drains fetch.
// Optional per-source accepted-redirect counters under REDIRECT_PERF_EN.
module fetch_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int EPOCH_W      = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rob_flush_valid,
  input  logic [XLEN-1:0]    rob_flush_pc,
  input  logic               ex_redir_valid,
  input  logic [XLEN-1:0]    ex_redir_pc,
  input  logic [EPOCH_W-1:0] ex_redir_epoch,
  input  logic               dec_redir_valid,
  input  logic [XLEN-1:0]    dec_redir_pc,
  input  logic [EPOCH_W-1:0] dec_redir_epoch,
  input  logic               fetch_ready,
  output logic               branch,
  output logic [XLEN-1:0]    branch_loc,
  output logic               kill_frontend,
  output logic               hold_fetch,
  output logic [EPOCH_W-1:0] cur_epoch,
  output logic               busy
`ifdef REDIRECT_PERF_EN
  ,
  output logic [31:0]        perf_rob_cnt,
  output logic [31:0]        perf_ex_cnt,
  output logic [31:0]        perf_dec_cnt
`endif
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {IDLE, PEND, DRAIN} state_t;
  // Encoding doubles as priority: a larger value wins.
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_DEC = 2'd1, SRC_EX = 2'd2, SRC_ROB = 2'd3} src_t;

  state_t             state, state_nx;
  src_t               pend_src, pend_src_nx, req_src;
  logic [XLEN-1:0]    pend_pc_nx, req_pc;
  logic [EPOCH_W-1:0] epoch_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               accept;

  always_comb begin
    req_src = SRC_NONE;
    req_pc  = '0;
    if (rob_flush_valid) begin
      req_src = SRC_ROB;
      req_pc  = rob_flush_pc;
    end else if (ex_redir_valid && (ex_redir_epoch == cur_epoch)) begin
      req_src = SRC_EX;
      req_pc  = ex_redir_pc;
    end else if (dec_redir_valid && (dec_redir_epoch == cur_epoch)) begin
      req_src = SRC_DEC;
      req_pc  = dec_redir_pc;
    end
  end

  assign accept        = (state == PEND) && fetch_ready;
  assign kill_frontend = accept;

  always_comb begin
    state_nx    = state;
    pend_src_nx = pend_src;
    pend_pc_nx  = branch_loc;
    epoch_nx    = cur_epoch;
    cnt_nx      = cnt;
    case (state)
      IDLE: begin
        if (req_src != SRC_NONE) begin
          state_nx    = PEND;
          pend_src_nx = req_src;
          pend_pc_nx  = req_pc;
        end
      end
      PEND: begin
        if (fetch_ready) begin
          epoch_nx = cur_epoch + EPOCH_W'(1);
          // Same-cycle ex/dec requests carry the old epoch and die; a flush survives.
          if (rob_flush_valid) begin
            state_nx    = PEND;
            pend_src_nx = SRC_ROB;
            pend_pc_nx  = rob_flush_pc;
          end else if (DRAIN_CYCLES == 0) begin
            state_nx    = IDLE;
            pend_src_nx = SRC_NONE;
          end else begin
            state_nx    = DRAIN;
            pend_src_nx = SRC_NONE;
            cnt_nx      = DRAIN_INIT;
          end
        end else if (req_src > pend_src) begin
          pend_src_nx = req_src;
          pend_pc_nx  = req_pc;
        end
      end
      DRAIN: begin
        if (req_src != SRC_NONE) begin
          state_nx    = PEND;
          pend_src_nx = req_src;
          pend_pc_nx  = req_pc;
          cnt_nx      = '0;
        end else if (cnt <= CNT_W'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx    = IDLE;
        pend_src_nx = SRC_NONE;
        cnt_nx      = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pend_src   <= SRC_NONE;
      branch_loc <= '0;
      cur_epoch  <= '0;
      cnt        <= '0;
      branch     <= 1'b0;
      hold_fetch <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      pend_src   <= pend_src_nx;
      branch_loc <= pend_pc_nx;
      cur_epoch  <= epoch_nx;
      cnt        <= cnt_nx;
      branch     <= (state_nx == PEND);
      hold_fetch <= (state_nx == DRAIN);
      busy       <= (state_nx != IDLE);
    end
  end

`ifdef REDIRECT_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_rob_cnt <= '0;
      perf_ex_cnt  <= '0;
      perf_dec_cnt <= '0;
    end else if (accept) begin
      case (pend_src)
        SRC_ROB: if (perf_rob_cnt != 32'hFFFF_FFFF) perf_rob_cnt <= perf_rob_cnt + 32'd1;
        SRC_EX:  if (perf_ex_cnt  != 32'hFFFF_FFFF) perf_ex_cnt  <= perf_ex_cnt  + 32'd1;
        SRC_DEC: if (perf_dec_cnt != 32'hFFFF_FFFF) perf_dec_cnt <= perf_dec_cnt + 32'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: a default-drain instance and a zero-drain
// instance, with perf-counter checks when REDIRECT_PERF_EN is defined.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rob_v, ex_v, dec_v, ready;
  logic [31:0] rob_pc, ex_pc, dec_pc;
  logic [1:0]  ex_ep, dec_ep;
  logic        branch, kill, hold, busy;
  logic [31:0] loc;
  logic [1:0]  epoch;

  logic        z_ex_v, z_ready;
  logic [31:0] z_ex_pc;
  logic [1:0]  z_ex_ep;
  logic        z_branch, z_kill, z_hold, z_busy;
  logic [31:0] z_loc;
  logic [1:0]  z_epoch;

`ifdef REDIRECT_PERF_EN
  logic [31:0] p_rob, p_ex, p_dec, z_p_rob, z_p_ex, z_p_dec;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.XLEN(32), .EPOCH_W(2), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .rob_flush_valid(rob_v), .rob_flush_pc(rob_pc),
    .ex_redir_valid(ex_v), .ex_redir_pc(ex_pc), .ex_redir_epoch(ex_ep),
    .dec_redir_valid(dec_v), .dec_redir_pc(dec_pc), .dec_redir_epoch(dec_ep),
    .fetch_ready(ready),
    .branch(branch), .branch_loc(loc), .kill_frontend(kill),
    .hold_fetch(hold), .cur_epoch(epoch), .busy(busy)
`ifdef REDIRECT_PERF_EN
    , .perf_rob_cnt(p_rob), .perf_ex_cnt(p_ex), .perf_dec_cnt(p_dec)
`endif
  );

  fetch_redirect_ctrl #(.XLEN(32), .EPOCH_W(2), .DRAIN_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset),
    .rob_flush_valid(1'b0), .rob_flush_pc(32'h0),
    .ex_redir_valid(z_ex_v), .ex_redir_pc(z_ex_pc), .ex_redir_epoch(z_ex_ep),
    .dec_redir_valid(1'b0), .dec_redir_pc(32'h0), .dec_redir_epoch(2'd0),
    .fetch_ready(z_ready),
    .branch(z_branch), .branch_loc(z_loc), .kill_frontend(z_kill),
    .hold_fetch(z_hold), .cur_epoch(z_epoch), .busy(z_busy)
`ifdef REDIRECT_PERF_EN
    , .perf_rob_cnt(z_p_rob), .perf_ex_cnt(z_p_ex), .perf_dec_cnt(z_p_dec)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives all main-instance inputs, then lets combinational outputs settle.
  task automatic applyStimulus(input logic rv, input logic [31:0] rp,
                               input logic ev, input logic [31:0] ep, input logic [1:0] ee,
                               input logic dv, input logic [31:0] dp, input logic [1:0] de,
                               input logic rdy);
    rob_v = rv; rob_pc = rp;
    ex_v = ev; ex_pc = ep; ex_ep = ee;
    dec_v = dv; dec_pc = dp; dec_ep = de;
    ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    z_ex_v = 1'b0; z_ex_pc = '0; z_ex_ep = '0; z_ready = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_branch", branch, 0);
    checkOutput("rst_loc", loc, 0);
    checkOutput("rst_kill", kill, 0);
    checkOutput("rst_hold", hold, 0);
    checkOutput("rst_epoch", epoch, 0);
    checkOutput("rst_busy", busy, 0);
    #10 reset = 1'b1;
    tick();

    $display("[TB] basic ex redirect with drain");
    applyStimulus(0, 0, 1, 32'h100, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("t1_branch", branch, 1);
    checkOutput("t1_loc", loc, 32'h100);
    checkOutput("t1_kill", kill, 1);
    checkOutput("t1_hold_pend", hold, 0);
    tick();
    checkOutput("t1_drain1_hold", hold, 1);
    checkOutput("t1_drain1_branch", branch, 0);
    checkOutput("t1_epoch", epoch, 1);
    checkOutput("t1_drain_kill", kill, 0);
    tick();
    checkOutput("t1_drain2_hold", hold, 1);
    tick();
    checkOutput("t1_idle_hold", hold, 0);
    checkOutput("t1_idle_busy", busy, 0);

    $display("[TB] ex beats dec in the same cycle");
    applyStimulus(0, 0, 1, 32'h300, 1, 1, 32'h200, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_loc", loc, 32'h300);
    checkOutput("t2_kill_notready", kill, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(); tick(); tick();
    checkOutput("t2_epoch", epoch, 2);
    checkOutput("t2_idle_busy", busy, 0);

    $display("[TB] held dec request preempted by rob flush");
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h400, 2, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_loc_dec", loc, 32'h400);
    tick(); tick();
    checkOutput("t3_loc_held", loc, 32'h400);
    checkOutput("t3_branch_held", branch, 1);
    applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 32'h500, 2, 0, 0, 0, 0);
    checkOutput("t3_loc_rob", loc, 32'h80);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("t3_loc_ex_ignored", loc, 32'h80);
    checkOutput("t3_kill", kill, 1);
    tick();
    checkOutput("t3_epoch", epoch, 3);
    checkOutput("t3_drain_hold", hold, 1);
    tick(); tick();

    $display("[TB] stale epoch dropped, drain abort, accept plus flush");
    applyStimulus(0, 0, 1, 32'h600, 0, 1, 32'h610, 1, 1);
    tick();
    checkOutput("t4_stale_branch", branch, 0);
    checkOutput("t4_stale_busy", busy, 0);
    applyStimulus(1, 32'h700, 0, 0, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("t4_rob_loc", loc, 32'h700);
    tick();
    checkOutput("t4_epoch_wrap", epoch, 0);
    checkOutput("t4_drain_hold", hold, 1);
    applyStimulus(0, 0, 1, 32'h800, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(1, 32'h900, 1, 32'hA00, 0, 0, 0, 0, 1);
    checkOutput("t4_abort_branch", branch, 1);
    checkOutput("t4_abort_hold", hold, 0);
    checkOutput("t4_abort_loc", loc, 32'h800);
    checkOutput("t4_abort_kill", kill, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("t4_flush_branch", branch, 1);
    checkOutput("t4_flush_loc", loc, 32'h900);
    checkOutput("t4_flush_hold", hold, 0);
    checkOutput("t4_flush_epoch", epoch, 1);
    tick();
    checkOutput("t4_final_epoch", epoch, 2);
    tick(); tick();
    checkOutput("t4_idle_busy", busy, 0);
`ifdef REDIRECT_PERF_EN
    checkOutput("perf_rob", p_rob, 3);
    checkOutput("perf_ex", p_ex, 3);
    checkOutput("perf_dec", p_dec, 0);
`endif

    $display("[TB] asynchronous reset while pending");
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hB00, 2, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_pre_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("t5_branch", branch, 0);
    checkOutput("t5_hold", hold, 0);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_epoch", epoch, 0);
    checkOutput("t5_loc", loc, 0);
    #2 reset = 1'b1;
    tick();

    $display("[TB] zero drain instance");
    z_ex_v = 1'b1; z_ex_pc = 32'h140; z_ex_ep = 2'd0; z_ready = 1'b1;
    tick();
    z_ex_v = 1'b0;
    #1;
    checkOutput("t6_branch", z_branch, 1);
    checkOutput("t6_loc", z_loc, 32'h140);
    checkOutput("t6_kill", z_kill, 1);
    tick();
    checkOutput("t6_idle_branch", z_branch, 0);
    checkOutput("t6_idle_hold", z_hold, 0);
    checkOutput("t6_idle_busy", z_busy, 0);
    checkOutput("t6_epoch1", z_epoch, 1);
`ifdef REDIRECT_PERF_EN
    checkOutput("t6_perf_ex1", z_p_ex, 1);
`endif
    z_ex_v = 1'b1; z_ex_pc = 32'h180; z_ex_ep = 2'd1;
    tick();
    z_ex_v = 1'b0;
    #1;
    checkOutput("t6_loc2", z_loc, 32'h180);
    checkOutput("t6_hold2", z_hold, 0);
    tick();
    checkOutput("t6_epoch2", z_epoch, 2);
    checkOutput("t6_hold_after2", z_hold, 0);
`ifdef REDIRECT_PERF_EN
    checkOutput("t6_perf_ex2", z_p_ex, 2);
    checkOutput("t6_perf_rob", z_p_rob, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
